rob_multiport: RTL and testbench
================================

ROB_MULTIPORT -- requirements
Module: rob_multiport

Interface
REQ-001 SHALL have parameter DEPTH_BIT, default 3, log2 of entry count (8 entries).
REQ-002 SHALL have parameter WB_PORTS, default 2, number of writeback ports.
REQ-003 SHALL have clk_in  input  1  system clock; the single clock, all state updates on rising edge.
REQ-004 SHALL have rst_in  input  1  reset, synchronous, active-high.
REQ-005 SHALL have rdy_in  input  1  global stall; low freezes all state.
REQ-006 SHALL have issue_valid/issue_ready  input/output  1/1  issue handshake.
REQ-007 SHALL have issue_type, issue_rd, issue_value, issue_done  input  2/5/32/1  type (RG=0, ST=1, BR=2), destination, initial value, already-complete flag.
REQ-008 SHALL have issue_idx  output  DEPTH_BIT  tail index allocated to the current issue.
REQ-009 SHALL have wb_valid, wb_idx, wb_value, wb_redirect  input  WB_PORTS, WB_PORTS*DEPTH_BIT, WB_PORTS*32, WB_PORTS  packed writeback ports; wb_redirect marks a branch misprediction.
REQ-010 SHALL have q_idx[1:2]  input  DEPTH_BIT each; q_ready[1:2]  output  1; q_value[1:2]  output  32; operand query.
REQ-011 SHALL have cm_reg_valid, cm_reg_rd, cm_reg_value, cm_reg_idx  output  2/10/64/2*DEPTH_BIT  per-slot register commit.
REQ-012 SHALL have cm_store  output  2  per-slot store-commit pulse to LSB; cm_head  output  DEPTH_BIT.
REQ-013 SHALL have flush, next_pc  output  1/32  registered misprediction redirect.

Function
REQ-014 SHALL accept an issue when issue_valid && issue_ready && rdy_in; issue_ready = !full && !flush, full/empty derived from a registered DEPTH_BIT+1-bit count.
REQ-015 SHALL write accepted entry at tail, set busy, done=issue_done; tail wraps modulo 2^DEPTH_BIT.
REQ-016 SHALL on wb_valid[p] to a busy entry set done, store wb_value, record wb_redirect; writeback to a non-busy entry SHALL be ignored.
REQ-017 SHALL, if two ports hit the same index in one cycle, let the higher-numbered port win.
REQ-018 SHALL resolve q_ready/q_value combinationally: stored value if done, else bypass from the highest matching wb port, else q_ready=0.
REQ-019 SHALL commit slot 0 when head entry busy && done; slot 1 commits head+1 only if slot 0 commits, entry busy && done, and slot 0 is not a redirecting BR.
REQ-020 SHALL drive cm_reg_valid only for committing RG entries with rd != 0; cm_store only for committing ST; commit outputs combinational, zero when rdy_in low.
REQ-021 SHALL update count = count + issued - committed; an entry freed this cycle SHALL NOT be reissued in the same cycle.
REQ-022 SHALL on committing a BR with redirect set flush<=1 and next_pc<=stored value at that edge.
REQ-023 SHALL, in the next rdy_in-high cycle with flush=1, clear all busy bits, head=tail=count=0, flush<=0; next_pc holds.
REQ-024 SHALL ignore writebacks and issues while flush=1.

Reset
REQ-025 SHALL on rst_in clear all entries, head, tail, count, flush, next_pc to 0; issue_ready=1 the following cycle; rst_in overrides rdy_in and flush.

Configuration
REQ-026 SHALL with ROB_DUAL_COMMIT_EN defined commit up to two entries per cycle; without it slot 1 outputs SHALL be tied to 0 and at most one entry committed per cycle.

Structure
REQ-027 SHALL take type encodings, ROB_TYPE_BIT and default widths from the shared config package/header.
REQ-028 SHALL place commit-slot selection in sub-module rob_commit_sel (head entries in, slot enables out).

Verification
REQ-029 Issue 8 RG entries, no writeback -> issue_ready=0 after 8th; 9th issue_valid not accepted, issue_idx stays 0.
REQ-030 Issue RG rd=5, wb port0 value 0x1234 -> q_ready=1, q_value=0x1234 same cycle; next cycle cm_reg_valid[0]=1, cm_reg_rd=5.
REQ-031 Ports 0 and 1 write idx 2 with 0xA/0xB same cycle -> stored value 0xB.
REQ-032 BR at head, wb_redirect=1 value 0x100, done RG behind it -> flush=1, next_pc=0x100, RG not committed; next cycle count=0, flush=0.
REQ-033 Two done RG entries at head: with ROB_DUAL_COMMIT_EN both commit in one cycle; without, two consecutive cycles.
REQ-034 rst_in asserted mid-stream with rdy_in=0 -> all outputs 0, issue_ready=1 after reset.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// rtl/rob_multiport_pkg.sv - shared entry types, encodings and default widths for the reorder buffer
package rob_multiport_pkg;

  localparam int ROB_TYPE_BIT      = 2;
  localparam int ROB_DATA_W        = 32;
  localparam int ROB_RD_W          = 5;
  localparam int ROB_DEPTH_BIT_DEF = 3;
  localparam int ROB_WB_PORTS_DEF  = 2;

  localparam logic [ROB_TYPE_BIT-1:0] ROB_T_RG = 2'd0;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_T_ST = 2'd1;
  localparam logic [ROB_TYPE_BIT-1:0] ROB_T_BR = 2'd2;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic                    redirect;
    logic [ROB_TYPE_BIT-1:0] typ;
    logic [ROB_RD_W-1:0]     rd;
    logic [ROB_DATA_W-1:0]   value;
  } rob_entry_t;

  // A live branch whose writeback reported a misprediction.
  function automatic logic is_redirect_br(input rob_entry_t e);
    return e.busy && (e.typ == ROB_T_BR) && e.redirect;
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - commit slot enables from the two oldest entries; ROB_DUAL_COMMIT_EN enables slot 1
module rob_commit_sel
  import rob_multiport_pkg::*;
(
  input  logic       i_rdy,
  input  logic       i_flush,
  input  rob_entry_t i_head0,
  input  rob_entry_t i_head1,
  output logic [1:0] o_en
);

  logic w_en0;
  logic w_unused_fields;

  // Nothing retires while stalled or while a redirect is waiting to be applied.
  assign w_en0 = i_rdy && !i_flush && i_head0.busy && i_head0.done;

`ifdef ROB_DUAL_COMMIT_EN
  // Slot 1 follows slot 0 in order, and never past a mispredicted branch.
  assign o_en = {w_en0 && i_head1.busy && i_head1.done && !is_redirect_br(i_head0), w_en0};
`else
  assign o_en = {1'b0, w_en0};
`endif

  assign w_unused_fields = ^{i_head0, i_head1};

endmodule

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - multi-writeback reorder buffer with operand query and in-order commit; ROB_DUAL_COMMIT_EN selects two commit slots
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter int DEPTH_BIT = ROB_DEPTH_BIT_DEF,
  parameter int WB_PORTS  = ROB_WB_PORTS_DEF
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [ROB_TYPE_BIT-1:0]        issue_type,
  input  logic [ROB_RD_W-1:0]            issue_rd,
  input  logic [ROB_DATA_W-1:0]          issue_value,
  input  logic                           issue_done,
  output logic [DEPTH_BIT-1:0]           issue_idx,
  input  logic [WB_PORTS-1:0]            wb_valid,
  input  logic [WB_PORTS*DEPTH_BIT-1:0]  wb_idx,
  input  logic [WB_PORTS*ROB_DATA_W-1:0] wb_value,
  input  logic [WB_PORTS-1:0]            wb_redirect,
  input  logic [DEPTH_BIT-1:0]           q_idx1,
  input  logic [DEPTH_BIT-1:0]           q_idx2,
  output logic                           q_ready1,
  output logic                           q_ready2,
  output logic [ROB_DATA_W-1:0]          q_value1,
  output logic [ROB_DATA_W-1:0]          q_value2,
  output logic [1:0]                     cm_reg_valid,
  output logic [2*ROB_RD_W-1:0]          cm_reg_rd,
  output logic [2*ROB_DATA_W-1:0]        cm_reg_value,
  output logic [2*DEPTH_BIT-1:0]         cm_reg_idx,
  output logic [1:0]                     cm_store,
  output logic [DEPTH_BIT-1:0]           cm_head,
  output logic                           flush,
  output logic [ROB_DATA_W-1:0]          next_pc
);

  localparam int DEPTH = 1 << DEPTH_BIT;
  localparam logic [DEPTH_BIT:0] CNT_FULL = {1'b1, {DEPTH_BIT{1'b0}}};

  rob_entry_t              r_ent [DEPTH];
  logic [DEPTH_BIT-1:0]    r_head;
  logic [DEPTH_BIT-1:0]    r_tail;
  logic [DEPTH_BIT:0]      r_count;
  logic                    r_flush;
  logic [ROB_DATA_W-1:0]   r_next_pc;

  logic                    w_full;
  logic                    w_issue;
  logic [1:0]              w_cm_en;
  logic [DEPTH_BIT:0]      w_n_commit;
  logic [DEPTH_BIT-1:0]    w_slot_idx [2];
  rob_entry_t              w_slot_ent [2];

  assign w_full      = (r_count == CNT_FULL);
  assign issue_ready = !w_full && !r_flush;
  assign w_issue     = issue_valid && issue_ready && rdy_in;
  assign issue_idx   = r_tail;
  assign cm_head     = r_head;
  assign flush       = r_flush;
  assign next_pc     = r_next_pc;

  assign w_slot_idx[0] = r_head;
  assign w_slot_idx[1] = r_head + DEPTH_BIT'(1);
  assign w_slot_ent[0] = r_ent[w_slot_idx[0]];
  assign w_slot_ent[1] = r_ent[w_slot_idx[1]];

  rob_commit_sel u_commit_sel (
    .i_rdy   (rdy_in),
    .i_flush (r_flush),
    .i_head0 (w_slot_ent[0]),
    .i_head1 (w_slot_ent[1]),
    .o_en    (w_cm_en)
  );

  assign w_n_commit = {{DEPTH_BIT{1'b0}}, w_cm_en[0]} + {{DEPTH_BIT{1'b0}}, w_cm_en[1]};

  // Operand lookup: stored result if done, else the highest-numbered writeback port hitting that index.
  function automatic logic [ROB_DATA_W:0] f_query(input logic [DEPTH_BIT-1:0] idx);
    logic [ROB_DATA_W:0] res;
    res = '0;
    if (r_ent[idx].done) begin
      res = {1'b1, r_ent[idx].value};
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_idx[p*DEPTH_BIT +: DEPTH_BIT] == idx)) begin
          res = {1'b1, wb_value[p*ROB_DATA_W +: ROB_DATA_W]};
        end
      end
    end
    return res;
  endfunction

  // Two independent combinational operand query ports.
  always_comb begin
    {q_ready1, q_value1} = f_query(q_idx1);
    {q_ready2, q_value2} = f_query(q_idx2);
  end

  // Commit outputs per slot; register fields are zero unless that slot writes a register.
  always_comb begin
    cm_reg_valid = '0;
    cm_store     = '0;
    cm_reg_rd    = '0;
    cm_reg_value = '0;
    cm_reg_idx   = '0;
    for (int s = 0; s < 2; s++) begin
      if (w_cm_en[s] && (w_slot_ent[s].typ == ROB_T_ST)) begin
        cm_store[s] = 1'b1;
      end
      if (w_cm_en[s] && (w_slot_ent[s].typ == ROB_T_RG) && (w_slot_ent[s].rd != '0)) begin
        cm_reg_valid[s]                           = 1'b1;
        cm_reg_rd[s*ROB_RD_W +: ROB_RD_W]         = w_slot_ent[s].rd;
        cm_reg_value[s*ROB_DATA_W +: ROB_DATA_W]  = w_slot_ent[s].value;
        cm_reg_idx[s*DEPTH_BIT +: DEPTH_BIT]      = w_slot_idx[s];
      end
    end
  end

  // Entry state, pointers, occupancy and redirect; writeback then retire then allocate.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_flush   <= 1'b0;
      r_next_pc <= '0;
    end else if (rdy_in) begin
      if (r_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_ent[i].busy <= 1'b0;
          r_ent[i].done <= 1'b0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_flush <= 1'b0;
      end else begin
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && r_ent[wb_idx[p*DEPTH_BIT +: DEPTH_BIT]].busy) begin
            r_ent[wb_idx[p*DEPTH_BIT +: DEPTH_BIT]].done     <= 1'b1;
            r_ent[wb_idx[p*DEPTH_BIT +: DEPTH_BIT]].value    <= wb_value[p*ROB_DATA_W +: ROB_DATA_W];
            r_ent[wb_idx[p*DEPTH_BIT +: DEPTH_BIT]].redirect <= wb_redirect[p];
          end
        end
        for (int s = 0; s < 2; s++) begin
          if (w_cm_en[s]) begin
            r_ent[w_slot_idx[s]].busy <= 1'b0;
            r_ent[w_slot_idx[s]].done <= 1'b0;
          end
        end
        if (w_issue) begin
          r_ent[r_tail] <= '{busy: 1'b1, done: issue_done, redirect: 1'b0,
                             typ: issue_type, rd: issue_rd, value: issue_value};
        end
        if (w_cm_en[0] && is_redirect_br(w_slot_ent[0])) begin
          r_flush   <= 1'b1;
          r_next_pc <= w_slot_ent[0].value;
        end else if (w_cm_en[1] && is_redirect_br(w_slot_ent[1])) begin
          r_flush   <= 1'b1;
          r_next_pc <= w_slot_ent[1].value;
        end
        r_head  <= r_head + w_n_commit[DEPTH_BIT-1:0];
        r_tail  <= r_tail + DEPTH_BIT'(w_issue);
        r_count <= r_count + {{DEPTH_BIT{1'b0}}, w_issue} - w_n_commit;
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - self-checking bench for rob_multiport: directed vectors plus randomized queue-model comparison
module tb_rob_multiport;
  import rob_multiport_pkg::*;

  localparam int NP = 2;
  localparam int N  = 8;
`ifdef ROB_DUAL_COMMIT_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_value;
  logic        issue_done;
  logic [2:0]  issue_idx;
  logic [1:0]  wb_valid;
  logic [5:0]  wb_idx;
  logic [63:0] wb_value;
  logic [1:0]  wb_redirect;
  logic [2:0]  q_idx1, q_idx2;
  logic        q_ready1, q_ready2;
  logic [31:0] q_value1, q_value2;
  logic [1:0]  cm_reg_valid;
  logic [9:0]  cm_reg_rd;
  logic [63:0] cm_reg_value;
  logic [5:0]  cm_reg_idx;
  logic [1:0]  cm_store;
  logic [2:0]  cm_head;
  logic        flush;
  logic [31:0] next_pc;

  int n_tests = 0;
  int n_fail  = 0;

  rob_multiport #(.DEPTH_BIT(3), .WB_PORTS(NP)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_value(issue_value), .issue_done(issue_done), .issue_idx(issue_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value), .wb_redirect(wb_redirect),
    .q_idx1(q_idx1), .q_idx2(q_idx2), .q_ready1(q_ready1), .q_ready2(q_ready2),
    .q_value1(q_value1), .q_value2(q_value2),
    .cm_reg_valid(cm_reg_valid), .cm_reg_rd(cm_reg_rd), .cm_reg_value(cm_reg_value),
    .cm_reg_idx(cm_reg_idx), .cm_store(cm_store), .cm_head(cm_head),
    .flush(flush), .next_pc(next_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_type = 0; issue_rd = 0; issue_value = 0; issue_done = 0;
    wb_valid = 0; wb_idx = 0; wb_value = 0; wb_redirect = 0; q_idx1 = 0; q_idx2 = 0;
  endtask

  task automatic do_reset();
    idle();
    rdy_in = 1; rst_in = 1;
    tick();
    rst_in = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] v, input logic d);
    issue_valid = 1; issue_type = t; issue_rd = rd; issue_value = v; issue_done = d;
    tick();
    issue_valid = 0;
  endtask

  // Query-table vectors
  typedef struct {
    logic [2:0]  q1, q2;
    logic [1:0]  wv;
    logic [5:0]  wi;
    logic [63:0] wd;
    logic        r1;
    logic [31:0] v1;
    logic        r2;
    logic [31:0] v2;
  } qvec_t;
  qvec_t tbl [6];

  // Reference model: program-ordered queue of live entries
  typedef struct {
    logic [2:0]  idx;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] value;
    bit          done;
    bit          redir;
  } ment_t;
  ment_t       mq [$];
  int          m_head, m_tail;
  bit          m_flush;
  logic [31:0] m_pc;
  bit          exp_ready, e0, e1, fl_set;
  ment_t       ent;
  logic [32:0] mqr;

  function automatic logic [32:0] model_q(input logic [2:0] idx);
    logic [32:0] r;
    r = '0;
    foreach (mq[i]) if (mq[i].idx == idx && mq[i].done) return {1'b1, mq[i].value};
    for (int p = 0; p < NP; p++)
      if (wb_valid[p] && wb_idx[p*3 +: 3] == idx) r = {1'b1, wb_value[p*32 +: 32]};
    return r;
  endfunction

  task automatic model_slot_chk(input int s, input bit en);
    ment_t me;
    bit rv, st;
    rv = 0; st = 0;
    if (en) begin
      me = mq[s];
      rv = (me.typ == ROB_T_RG) && (me.rd != 0);
      st = (me.typ == ROB_T_ST);
    end
    chk($sformatf("rnd cm_reg_valid[%0d]", s), 64'(cm_reg_valid[s]), 64'(rv));
    chk($sformatf("rnd cm_store[%0d]", s), 64'(cm_store[s]), 64'(st));
    if (rv) begin
      chk($sformatf("rnd cm_reg_rd[%0d]", s), 64'(cm_reg_rd[s*5 +: 5]), 64'(me.rd));
      chk($sformatf("rnd cm_reg_value[%0d]", s), 64'(cm_reg_value[s*32 +: 32]), 64'(me.value));
      chk($sformatf("rnd cm_reg_idx[%0d]", s), 64'(cm_reg_idx[s*3 +: 3]), 64'(me.idx));
    end
  endtask

  initial begin
    do_reset();

    // Reset state
    chk("rst issue_ready", 64'(issue_ready), 64'd1);
    chk("rst issue_idx", 64'(issue_idx), 64'd0);
    chk("rst cm_head", 64'(cm_head), 64'd0);
    chk("rst flush", 64'(flush), 64'd0);
    chk("rst next_pc", 64'(next_pc), 64'd0);
    chk("rst cm_reg_valid", 64'(cm_reg_valid), 64'd0);

    // Fill to capacity, ninth issue refused
    issue_valid = 1; issue_type = ROB_T_RG; issue_done = 0;
    for (int i = 0; i < 7; i++) begin
      issue_rd = 5'(i + 1);
      tick();
    end
    chk("fill7 issue_ready", 64'(issue_ready), 64'd1);
    chk("fill7 issue_idx", 64'(issue_idx), 64'd7);
    tick();
    chk("full issue_ready", 64'(issue_ready), 64'd0);
    chk("full issue_idx", 64'(issue_idx), 64'd0);
    tick();
    chk("ninth issue_ready", 64'(issue_ready), 64'd0);
    chk("ninth issue_idx", 64'(issue_idx), 64'd0);
    issue_valid = 0;

    // Writeback bypass and next-cycle commit
    do_reset();
    issue(ROB_T_RG, 5'd5, 32'h0, 1'b0);
    wb_valid = 2'b01; wb_idx = 6'd0; wb_value = 64'h1234; q_idx1 = 3'd0;
    #1;
    chk("byp q_ready1", 64'(q_ready1), 64'd1);
    chk("byp q_value1", 64'(q_value1), 64'h1234);
    chk("byp no commit yet", 64'(cm_reg_valid), 64'd0);
    tick();
    idle();
    #1;
    chk("cm0 valid", 64'(cm_reg_valid), 64'b01);
    chk("cm0 rd", 64'(cm_reg_rd[4:0]), 64'd5);
    chk("cm0 value", 64'(cm_reg_value[31:0]), 64'h1234);
    chk("cm0 idx", 64'(cm_reg_idx[2:0]), 64'd0);

    // Same-index writeback on both ports: port 1 wins
    do_reset();
    issue(ROB_T_RG, 5'd1, 32'h0, 1'b0);
    issue(ROB_T_RG, 5'd2, 32'h0, 1'b0);
    issue(ROB_T_RG, 5'd3, 32'h0, 1'b0);
    wb_valid = 2'b11; wb_idx = {3'd2, 3'd2}; wb_value = {32'hB, 32'hA};
    tick();
    idle();
    q_idx1 = 3'd2;
    #1;
    chk("dual wb ready", 64'(q_ready1), 64'd1);
    chk("dual wb value", 64'(q_value1), 64'hB);

    // Mispredicted branch at head with a done RG behind it
    do_reset();
    issue(ROB_T_BR, 5'd0, 32'h0, 1'b0);
    issue(ROB_T_RG, 5'd3, 32'h7, 1'b1);
    wb_valid = 2'b01; wb_idx = 6'd0; wb_value = 64'h100; wb_redirect = 2'b01;
    tick();
    idle();
    #1;
    chk("br commit cm_reg_valid", 64'(cm_reg_valid), 64'd0);
    tick();
    chk("br flush", 64'(flush), 64'd1);
    chk("br next_pc", 64'(next_pc), 64'h100);
    chk("br issue_ready", 64'(issue_ready), 64'd0);
    chk("br cm_head", 64'(cm_head), 64'd1);
    chk("br rg blocked", 64'(cm_reg_valid), 64'd0);
    tick();
    chk("post flush", 64'(flush), 64'd0);
    chk("post next_pc", 64'(next_pc), 64'h100);
    chk("post issue_ready", 64'(issue_ready), 64'd1);
    chk("post issue_idx", 64'(issue_idx), 64'd0);
    chk("post cm_head", 64'(cm_head), 64'd0);
    chk("post cm_reg_valid", 64'(cm_reg_valid), 64'd0);

    // Two done RG entries at head
    do_reset();
    issue(ROB_T_RG, 5'd1, 32'h1, 1'b0);
    issue(ROB_T_RG, 5'd2, 32'h2, 1'b1);
    wb_valid = 2'b01; wb_idx = 6'd0; wb_value = 64'h1;
    tick();
    idle();
    #1;
`ifdef ROB_DUAL_COMMIT_EN
    chk("two-head valid", 64'(cm_reg_valid), 64'b11);
    chk("two-head rd", 64'(cm_reg_rd), 64'({5'd2, 5'd1}));
    tick();
    chk("two-head after", 64'(cm_reg_valid), 64'd0);
`else
    chk("two-head c1 valid", 64'(cm_reg_valid), 64'b01);
    chk("two-head c1 rd", 64'(cm_reg_rd[4:0]), 64'd1);
    tick();
    chk("two-head c2 valid", 64'(cm_reg_valid), 64'b01);
    chk("two-head c2 rd", 64'(cm_reg_rd[4:0]), 64'd2);
    chk("two-head c2 idx", 64'(cm_reg_idx[2:0]), 64'd1);
`endif

    // Reset mid-stream while stalled with a redirect pending
    do_reset();
    issue(ROB_T_BR, 5'd0, 32'h0, 1'b0);
    issue(ROB_T_RG, 5'd4, 32'h9, 1'b0);
    wb_valid = 2'b01; wb_idx = 6'd0; wb_value = 64'h40; wb_redirect = 2'b01;
    tick();
    idle();
    tick();
    chk("pre-rst flush", 64'(flush), 64'd1);
    chk("pre-rst next_pc", 64'(next_pc), 64'h40);
    rdy_in = 0; rst_in = 1;
    tick();
    rst_in = 0;
    chk("rst2 flush", 64'(flush), 64'd0);
    chk("rst2 next_pc", 64'(next_pc), 64'd0);
    chk("rst2 issue_idx", 64'(issue_idx), 64'd0);
    chk("rst2 cm_head", 64'(cm_head), 64'd0);
    chk("rst2 cm outputs", {cm_reg_valid, cm_store, cm_reg_idx, cm_reg_rd}, 64'd0);
    chk("rst2 cm_reg_value", cm_reg_value, 64'd0);
    chk("rst2 q_ready", 64'({q_ready1, q_ready2}), 64'd0);
    chk("rst2 issue_ready", 64'(issue_ready), 64'd1);
    rdy_in = 1;

    // Table-driven operand queries against a frozen buffer
    do_reset();
    issue(ROB_T_RG, 5'd1, 32'hA0, 1'b0);
    issue(ROB_T_RG, 5'd2, 32'h22, 1'b1);
    issue(ROB_T_ST, 5'd0, 32'h33, 1'b0);
    rdy_in = 0;
    tbl[0] = '{3'd1, 3'd0, 2'b00, 6'd0,              {32'h0,  32'h0},  1'b1, 32'h22, 1'b0, 32'h0};
    tbl[1] = '{3'd0, 3'd2, 2'b01, {3'd0, 3'd0},      {32'h0,  32'h55}, 1'b1, 32'h55, 1'b0, 32'h0};
    tbl[2] = '{3'd0, 3'd2, 2'b11, {3'd0, 3'd0},      {32'h66, 32'h55}, 1'b1, 32'h66, 1'b0, 32'h0};
    tbl[3] = '{3'd1, 3'd2, 2'b11, {3'd1, 3'd2},      {32'h77, 32'h88}, 1'b1, 32'h22, 1'b1, 32'h88};
    tbl[4] = '{3'd2, 3'd0, 2'b11, {3'd0, 3'd2},      {32'hAB, 32'h99}, 1'b1, 32'h99, 1'b1, 32'hAB};
    tbl[5] = '{3'd3, 3'd3, 2'b00, 6'd0,              {32'h0,  32'h0},  1'b0, 32'h0,  1'b0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      q_idx1 = tbl[i].q1; q_idx2 = tbl[i].q2;
      wb_valid = tbl[i].wv; wb_idx = tbl[i].wi; wb_value = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d q_ready1", i), 64'(q_ready1), 64'(tbl[i].r1));
      chk($sformatf("tbl%0d q_ready2", i), 64'(q_ready2), 64'(tbl[i].r2));
      if (tbl[i].r1) chk($sformatf("tbl%0d q_value1", i), 64'(q_value1), 64'(tbl[i].v1));
      if (tbl[i].r2) chk($sformatf("tbl%0d q_value2", i), 64'(q_value2), 64'(tbl[i].v2));
    end
    idle();
    rdy_in = 1;

    // Randomized traffic against the queue model
    do_reset();
    mq.delete(); m_head = 0; m_tail = 0; m_flush = 0; m_pc = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      issue_valid = $urandom_range(0, 1) != 0;
      issue_type  = 2'($urandom_range(0, 2));
      issue_rd    = 5'($urandom_range(0, 3));
      issue_value = $urandom;
      issue_done  = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < NP; p++) begin
        wb_valid[p] = ($urandom_range(0, 2) == 0);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0)
          wb_idx[p*3 +: 3] = mq[$urandom_range(0, mq.size() - 1)].idx;
        else
          wb_idx[p*3 +: 3] = 3'($urandom_range(0, 7));
        wb_value[p*32 +: 32] = $urandom;
        wb_redirect[p] = ($urandom_range(0, 5) == 0);
      end
      q_idx1 = 3'($urandom_range(0, 7));
      q_idx2 = 3'($urandom_range(0, 7));
      #1;
      exp_ready = !m_flush && (mq.size() < N);
      chk("rnd issue_ready", 64'(issue_ready), 64'(exp_ready));
      chk("rnd issue_idx", 64'(issue_idx), 64'(m_tail));
      chk("rnd cm_head", 64'(cm_head), 64'(m_head));
      chk("rnd flush", 64'(flush), 64'(m_flush));
      chk("rnd next_pc", 64'(next_pc), 64'(m_pc));
      e0 = rdy_in && !m_flush && (mq.size() > 0) && mq[0].done;
      e1 = DUAL && e0 && (mq.size() > 1) && mq[1].done && !(mq[0].typ == ROB_T_BR && mq[0].redir);
      model_slot_chk(0, e0);
      model_slot_chk(1, e1);
      mqr = model_q(q_idx1);
      chk("rnd q_ready1", 64'(q_ready1), 64'(mqr[32]));
      if (mqr[32]) chk("rnd q_value1", 64'(q_value1), 64'(mqr[31:0]));
      mqr = model_q(q_idx2);
      chk("rnd q_ready2", 64'(q_ready2), 64'(mqr[32]));
      if (mqr[32]) chk("rnd q_value2", 64'(q_value2), 64'(mqr[31:0]));
      tick();
      if (rdy_in) begin
        if (m_flush) begin
          mq.delete(); m_head = 0; m_tail = 0; m_flush = 0;
        end else begin
          fl_set = 0;
          for (int k = 0; k < int'(e0) + int'(e1); k++) begin
            ent = mq.pop_front();
            if (ent.typ == ROB_T_BR && ent.redir && !fl_set) begin
              fl_set = 1; m_flush = 1; m_pc = ent.value;
            end
          end
          m_head = (m_head + int'(e0) + int'(e1)) % N;
          for (int p = 0; p < NP; p++) begin
            if (wb_valid[p]) begin
              foreach (mq[i]) begin
                if (mq[i].idx == wb_idx[p*3 +: 3]) begin
                  mq[i].done = 1; mq[i].value = wb_value[p*32 +: 32]; mq[i].redir = wb_redirect[p];
                end
              end
            end
          end
          if (issue_valid && exp_ready) begin
            ent.idx = 3'(m_tail); ent.typ = issue_type; ent.rd = issue_rd;
            ent.value = issue_value; ent.done = issue_done; ent.redir = 0;
            mq.push_back(ent);
            m_tail = (m_tail + 1) % N;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
